nios_fprint_input_pio: RTL

Parametrised Avalon-MM input PIO for the Nios fingerprinting system; successor to the 2-bit button PIO. It synchronises WIDTH external inputs, optionally debounces them, and captures rising and/or falling edges per bit under software control. It raises a level interrupt to the Nios IRQ controller when any masked captured edge is pending.

---
 rtl/nios_fprint_input_pio.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/nios_fprint_input_pio.sv
`timescale 1ns/1ps
// nios_fprint_input_pio
// Avalon-MM input PIO: synchronises WIDTH external inputs, optionally
// debounces them, captures enabled rising/falling edges and raises a level
// IRQ while any masked captured edge is pending.
// Optional feature macro: NIOS_FPRINT_PIO_DEBOUNCE_EN builds per-bit debounce
// counters (DEBOUNCE_CYCLES applies); otherwise stable follows sync2 directly.
module nios_fprint_input_pio #(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_RISE_EN  = 3'd1;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
    localparam logic [2:0] ADDR_FALL_EN  = 3'd4;
    localparam logic [2:0] ADDR_IRQ_STAT = 3'd5;

    logic [WIDTH-1:0] sync1_reg;
    logic [WIDTH-1:0] sync2_reg;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_d_reg;
    logic [WIDTH-1:0] rise_en_reg;
    logic [WIDTH-1:0] irq_mask_reg;
    logic [WIDTH-1:0] fall_en_reg;
    logic [WIDTH-1:0] edge_cap_reg;
    logic [WIDTH-1:0] edge_cap_next;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_set;
    logic [WIDTH-1:0] edge_clr;
    logic [31:0]      readdata_next;
    logic             wr_en;
    logic             unused_writedata;

    assign wr_en            = chipselect & ~write_n;
    assign wdata            = writedata[WIDTH-1:0];
    // Only the low WIDTH bits of a write carry meaning.
    assign unused_writedata = ^writedata;

    // Two-flop synchroniser for the asynchronous inputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= in_port;
            sync2_reg <= sync1_reg;
        end
    end

`ifdef NIOS_FPRINT_PIO_DEBOUNCE_EN
    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_debounce
            logic [CNT_W-1:0] cnt_reg;
            logic             stable_bit_reg;

            // Accept a new level only after it has differed from the
            // current stable value for DEBOUNCE_CYCLES consecutive cycles.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_reg        <= '0;
                    stable_bit_reg <= 1'b0;
                end else if (sync2_reg[gi] == stable_bit_reg) begin
                    cnt_reg <= '0;
                end else if (cnt_reg == CNT_LAST) begin
                    cnt_reg        <= '0;
                    stable_bit_reg <= sync2_reg[gi];
                end else begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end

            assign stable[gi] = stable_bit_reg;
        end
    endgenerate
`else
    localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

    assign stable = sync2_reg;
`endif

    // Delayed copy of the conditioned value for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_d_reg <= '0;
        end else begin
            stable_d_reg <= stable;
        end
    end

    // Edge capture: a newly detected edge overrides a same-cycle W1C.
    always_comb begin
        rise          = stable & ~stable_d_reg;
        fall          = ~stable & stable_d_reg;
        edge_set      = (rise & rise_en_reg) | (fall & fall_en_reg);
        edge_clr      = '0;
        if (wr_en && (address == ADDR_EDGE_CAP)) begin
            edge_clr = wdata;
        end
        edge_cap_next = (edge_cap_reg & ~edge_clr) | edge_set;
    end

    // Edge capture register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_cap_reg <= '0;
        end else begin
            edge_cap_reg <= edge_cap_next;
        end
    end

    // Software-writable control registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rise_en_reg  <= '1;
            irq_mask_reg <= '0;
            fall_en_reg  <= '0;
        end else if (wr_en) begin
            case (address)
                ADDR_RISE_EN:  rise_en_reg  <= wdata;
                ADDR_IRQ_MASK: irq_mask_reg <= wdata;
                ADDR_FALL_EN:  fall_en_reg  <= wdata;
                default: ;
            endcase
        end
    end

    // Read mux; unused upper bits and unmapped addresses read as zero.
    always_comb begin
        readdata_next = '0;
        case (address)
            ADDR_DATA:     readdata_next[WIDTH-1:0] = stable;
            ADDR_RISE_EN:  readdata_next[WIDTH-1:0] = rise_en_reg;
            ADDR_IRQ_MASK: readdata_next[WIDTH-1:0] = irq_mask_reg;
            ADDR_EDGE_CAP: readdata_next[WIDTH-1:0] = edge_cap_reg;
            ADDR_FALL_EN:  readdata_next[WIDTH-1:0] = fall_en_reg;
            ADDR_IRQ_STAT: readdata_next[WIDTH-1:0] = edge_cap_reg & irq_mask_reg;
            default:       readdata_next = '0;
        endcase
    end

    // Registered read data, refreshed every cycle regardless of chipselect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= readdata_next;
        end
    end

    assign irq = |(edge_cap_reg & irq_mask_reg);

endmodule
